mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu.sv | 166 ++++++++++++++++
 tb/tb_mdu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// MDU request/response bundle.
// Requester drives operands; MDU returns ready/valid/result.
interface mdu_if;
    logic        i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_flush;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;

    modport master (
        output i_valid, i_funct3, i_op1, i_op2, i_flush,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_funct3, i_op1, i_op2, i_flush,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit.
// Fixed 32-step shift-add / restoring divide on magnitudes.
module mdu (
    input  logic i_clk,
    input  logic i_rst,
    mdu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] a_q, a_d;
    logic [63:0] acc_q, acc_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;

    logic        s1, s2;
    logic [31:0] m1, m2;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] acc_step;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] fin;

    // Operand signedness and magnitudes for an incoming request.
    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        case (bus.i_funct3)
            3'b001, 3'b100, 3'b110: begin
                s1 = bus.i_op1[31];
                s2 = bus.i_op2[31];
            end
            3'b010: s1 = bus.i_op1[31];
            default: ;
        endcase
        m1 = s1 ? -bus.i_op1 : bus.i_op1;
        m2 = s2 ? -bus.i_op2 : bus.i_op2;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]}
                + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        div_ge  = acc_q[63:31] >= {1'b0, a_q};
        div_sub = acc_q[62:31] - a_q;
        if (f3_q[2]) begin
            acc_step = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                              : {acc_q[62:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[31:1]};
        end
    end

    // Sign correction and result selection for the final step.
    always_comb begin
        prod = negq_q ? -acc_step : acc_step;
        quo  = negq_q ? -acc_step[31:0] : acc_step[31:0];
        rem  = negr_q ? -acc_step[63:32] : acc_step[63:32];
        case (f3_q)
            3'b000:                 fin = prod[31:0];
            3'b001, 3'b010, 3'b011: fin = prod[63:32];
            3'b100, 3'b101:         fin = quo;
            default:                fin = rem;
        endcase
    end

    // Next-state logic; flush overrides accept and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        res_d   = res_q;
        if (bus.i_flush) begin
            state_d = IDLE;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        state_d = CALC;
                        ready_d = 1'b0;
                        cnt_d   = 5'd0;
                        f3_d    = bus.i_funct3;
                        // Zero divisor keeps the all-ones quotient unsigned.
                        negq_d  = (s1 ^ s2) & (bus.i_op2 != 32'd0);
                        negr_d  = s1;
                        if (bus.i_funct3[2]) begin
                            a_d   = m2;
                            acc_d = {32'd0, m1};
                        end else begin
                            a_d   = m1;
                            acc_d = {32'd0, m2};
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        res_d   = fin;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs; reset has top priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            f3_q    <= 3'd0;
            a_q     <= 32'd0;
            acc_q   <= 64'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = res_q;

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for the iterative MDU.
// Covers all ops, special cases, latency, flush and reset.
module tb_mdu;

    logic clk = 1'b0;
    logic rst;

    mdu_if bus ();

    mdu dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pops one expected result.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            chk("sb_pending_on_valid", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) chk("result", bus.o_result, sb.pop_front());
        end
    end

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.o_ready === 1'b1);
        end
        if (!ok) chk({tag, "_ready_timeout"}, {31'd0, bus.o_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp,
                          input string tag);
        int first;
        int width;
        wait_ready(tag);
        bus.i_valid  = 1'b1;
        bus.i_funct3 = f;
        bus.i_op1    = a;
        bus.i_op2    = b;
        sb.push_back(exp);
        last_exp = exp;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_funct3 = 3'($urandom);
        bus.i_op1    = $urandom;
        bus.i_op2    = $urandom;
        first = 0;
        width = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                width++;
                if (first == 0) first = n;
            end
            if (n == 1)
                chk({tag, "_ready_calc"}, {31'd0, bus.o_ready}, 32'd0);
            if (n == 33)
                chk({tag, "_ready_done"}, {31'd0, bus.o_ready}, 32'd0);
            if (n == 34)
                chk({tag, "_ready_after"}, {31'd0, bus.o_ready}, 32'd1);
            if (n <= 31) begin
                bus.i_valid = 1'($urandom);
                bus.i_op1   = $urandom;
                bus.i_op2   = $urandom;
            end else begin
                bus.i_valid = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(first), 32'd33);
        chk({tag, "_width"}, 32'(width), 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int vcnt;
        vcnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) vcnt++;
        end
        chk({tag, "_no_valid"}, 32'(vcnt), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_flush  = 1'b1;
        bus.i_funct3 = 3'd0;
        bus.i_op1    = 32'd3;
        bus.i_op2    = 32'd4;
        last_exp     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run_op(3'b001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, "mulh_neg");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu");
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, "remu");
        run_op(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by0");
        run_op(3'b111, 32'd5, 32'd0, 32'h00000005, "remu_by0");
        run_op(3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_neg_by0");
        run_op(3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_neg_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");

        // Flush at cycle 10 of a MUL with busy inputs.
        wait_ready("flush");
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'b000;
        bus.i_op1    = 32'd3;
        bus.i_op2    = 32'd5;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n < 10) begin
                bus.i_valid = 1'($urandom);
                bus.i_op1   = $urandom;
            end else begin
                bus.i_valid = 1'b0;
                bus.i_flush = 1'b1;
            end
        end
        @(negedge clk);
        bus.i_flush = 1'b0;
        chk("flush_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("flush_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("flush_result", bus.o_result, last_exp);
        quiet("flush", 40);
        run_op(3'b101, 32'd100, 32'd7, 32'h0000000E, "divu_after_flush");

        // Reset at cycle 20 of a DIV.
        wait_ready("rst_mid");
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'b100;
        bus.i_op1    = 32'd1000;
        bus.i_op2    = 32'd3;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst_mid_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_mid_result", bus.o_result, 32'd0);
        quiet("rst_mid", 40);
        chk("rst_mid_hold", bus.o_result, 32'd0);
        run_op(3'b000, 32'h12345678, 32'h10, 32'h23456780, "mul_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
